// File: rtl/sfx_sample_player.sv
// Single-voice sound-effect player: walks a clip in a registered-read sample ROM and
// hands one attenuated sample per DIV clocks to the codec. Stereo panning via SFX_STEREO_PAN_EN.
module sfx_sample_player #(
    parameter int unsigned SAMPLE_W = 6,
    parameter int unsigned ADDR_W   = 14,
    parameter int unsigned OUT_W    = 32,
    parameter int unsigned DIV      = 1200
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic                start,
    input  logic                stop,
    input  logic                loop_en,
    input  logic [ADDR_W-1:0]   clip_base,
    input  logic [ADDR_W-1:0]   clip_len,
    input  logic [2:0]          volume,
`ifdef SFX_STEREO_PAN_EN
    input  logic [1:0]          pan,
`endif
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [SAMPLE_W-1:0] rom_q,
    input  logic                audio_out_allowed,
    output logic                write_out,
    output logic [OUT_W-1:0]    left_out,
    output logic [OUT_W-1:0]    right_out,
    output logic                busy,
    output logic                done,
    output logic                overrun
);

    localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {StIdle, StFetch, StLatch, StPush, StPace} state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W-1:0]   len_q;
    logic [ADDR_W-1:0]   idx_q;
    logic                loop_q;
    logic [DivW-1:0]     div_cnt_q;
    logic                pend_q;
    logic                write_q;
    logic [OUT_W-1:0]    left_q;
    logic                done_q;
    logic                overrun_q;

    logic                tick;
    logic                start_ok;
    logic                last;
    logic signed [OUT_W-1:0] sample_wide;
    logic [OUT_W-1:0]    lat_left;

    assign tick     = (div_cnt_q == DivW'(DIV - 1));
    assign start_ok = start && (clip_len != '0);
    assign last     = (idx_q == len_q - ADDR_W'(1));

    // Sample lands in the top bits of the codec word; >>> keeps the sign while attenuating.
    assign sample_wide = OUT_W'($signed(rom_q)) <<< (OUT_W - SAMPLE_W);

`ifdef SFX_STEREO_PAN_EN
    logic [OUT_W-1:0] right_q;
    logic [OUT_W-1:0] lat_right;
    logic [3:0]       vol_p1;

    assign vol_p1 = {1'b0, volume} + 4'd1;

    always_comb begin
        lat_left  = sample_wide >>> volume;
        lat_right = sample_wide >>> volume;
        case (pan)
            2'b01:   lat_right = sample_wide >>> vol_p1;
            2'b10:   lat_left  = sample_wide >>> vol_p1;
            2'b11:   lat_right = '0;
            default: ;
        endcase
    end

    assign right_out = right_q;
`else
    assign lat_left  = sample_wide >>> volume;
    assign right_out = '0;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            base_q    <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            loop_q    <= 1'b0;
            div_cnt_q <= '0;
            pend_q    <= 1'b0;
            write_q   <= 1'b0;
            left_q    <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef SFX_STEREO_PAN_EN
            right_q   <= '0;
`endif
        end else begin
            done_q    <= 1'b0;
            div_cnt_q <= tick ? '0 : div_cnt_q + DivW'(1);
            if (stop) begin
                state_q   <= StIdle;
                write_q   <= 1'b0;
                left_q    <= '0;
                pend_q    <= 1'b0;
                div_cnt_q <= '0;
`ifdef SFX_STEREO_PAN_EN
                right_q   <= '0;
`endif
            end else if (start_ok) begin
                // Retrigger shares this path: any unaccepted sample is simply dropped.
                base_q    <= clip_base;
                len_q     <= clip_len;
                loop_q    <= loop_en;
                addr_q    <= clip_base;
                idx_q     <= '0;
                overrun_q <= 1'b0;
                pend_q    <= 1'b0;
                div_cnt_q <= '0;
                write_q   <= 1'b0;
                state_q   <= StFetch;
            end else begin
                if (tick && (state_q == StFetch || state_q == StLatch || state_q == StPush)) begin
                    if (pend_q) begin
                        overrun_q <= 1'b1;
                    end
                    pend_q <= 1'b1;
                end
                case (state_q)
                    StIdle: begin
                        div_cnt_q <= '0;
                    end
                    StFetch: begin
                        state_q <= StLatch;
                    end
                    StLatch: begin
                        left_q  <= lat_left;
`ifdef SFX_STEREO_PAN_EN
                        right_q <= lat_right;
`endif
                        write_q <= 1'b1;
                        state_q <= StPush;
                    end
                    StPush: begin
                        if (audio_out_allowed) begin
                            write_q <= 1'b0;
                            state_q <= StPace;
                        end
                    end
                    StPace: begin
                        if (tick || pend_q) begin
                            pend_q <= 1'b0;
                            if (last && loop_q) begin
                                idx_q   <= '0;
                                addr_q  <= base_q;
                                state_q <= StFetch;
                            end else if (last) begin
                                done_q    <= 1'b1;
                                left_q    <= '0;
                                div_cnt_q <= '0;
`ifdef SFX_STEREO_PAN_EN
                                right_q   <= '0;
`endif
                                state_q   <= StIdle;
                            end else begin
                                idx_q   <= idx_q + ADDR_W'(1);
                                addr_q  <= addr_q + ADDR_W'(1);
                                state_q <= StFetch;
                            end
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign rom_addr  = addr_q;
    assign write_out = write_q;
    assign left_out  = left_q;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sfx_sample_player.sv
// Scoreboard bench for sfx_sample_player: directed clips push expected codec writes,
// a monitor pops and compares each accepted write (value and cycle).
module tb_sfx_sample_player;

    localparam int unsigned SAMPLE_W = 6;
    localparam int unsigned ADDR_W   = 14;
    localparam int unsigned OUT_W    = 32;
    localparam int unsigned DIV      = 16;

    logic                clk = 1'b0;
    logic                resetn;
    logic                start;
    logic                stop;
    logic                loop_en;
    logic [ADDR_W-1:0]   clip_base;
    logic [ADDR_W-1:0]   clip_len;
    logic [2:0]          volume;
    logic [ADDR_W-1:0]   rom_addr;
    logic [SAMPLE_W-1:0] rom_q;
    logic                allowed;
    logic                write_out;
    logic [OUT_W-1:0]    left_out;
    logic [OUT_W-1:0]    right_out;
    logic                busy;
    logic                done;
    logic                overrun;

    logic [SAMPLE_W-1:0] rom [0:(1<<ADDR_W)-1];

    typedef struct {
        logic [OUT_W-1:0] left;
        int               cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    sfx_sample_player #(
        .SAMPLE_W(SAMPLE_W),
        .ADDR_W  (ADDR_W),
        .OUT_W   (OUT_W),
        .DIV     (DIV)
    ) dut (
        .CLOCK_50         (clk),
        .resetn           (resetn),
        .start            (start),
        .stop             (stop),
        .loop_en          (loop_en),
        .clip_base        (clip_base),
        .clip_len         (clip_len),
        .volume           (volume),
`ifdef SFX_STEREO_PAN_EN
        .pan              (2'b00),
`endif
        .rom_addr         (rom_addr),
        .rom_q            (rom_q),
        .audio_out_allowed(allowed),
        .write_out        (write_out),
        .left_out         (left_out),
        .right_out        (right_out),
        .busy             (busy),
        .done             (done),
        .overrun          (overrun)
    );

    always @(posedge clk) begin
        rom_q <= rom[rom_addr];
        cyc   <= cyc + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
    endtask

    task automatic goto_cyc(input int t);
        while (cyc < t) step(1);
    endtask

    task automatic push(input logic [OUT_W-1:0] l, input int c);
        exp_t e;
        e.left = l;
        e.cyc  = c;
        sb_q.push_back(e);
    endtask

    // Drives a start at the current negedge; n is the edge that samples it.
    task automatic launch(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] l,
                          input logic lp, input logic [2:0] v, output int n);
        clip_base = b;
        clip_len  = l;
        loop_en   = lp;
        volume    = v;
        start     = 1'b1;
        n         = cyc + 1;
        step(1);
        start     = 1'b0;
    endtask

    // Inputs settle at the negedge, so +1 sees exactly what the next posedge samples.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (resetn === 1'b1 && write_out === 1'b1 && allowed === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got write left=%0h expected none (cyc %0d)",
                         left_out, cyc);
            end else begin
                e = sb_q.pop_front();
                chk("sb_left", left_out, e.left);
                chk("sb_cycle", cyc, e.cyc);
`ifdef SFX_STEREO_PAN_EN
                chk("sb_right", right_out, e.left);
`else
                chk("sb_right", right_out, '0);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int n2;
        for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = '0;
        rom[100]   = 6'd5;
        rom[101]   = 6'h3D;
        rom[102]   = 6'd31;
        rom[16383] = 6'd7;
        rom[0]     = 6'h3F;
        rom[200]   = 6'h20;
        rom[201]   = 6'd1;
        rom[300]   = 6'd10;
        rom[301]   = 6'h36;

        resetn    = 1'b0;
        start     = 1'b1;
        stop      = 1'b0;
        loop_en   = 1'b0;
        clip_base = 14'd100;
        clip_len  = 14'd3;
        volume    = 3'd0;
        allowed   = 1'b1;
        step(3);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_write", write_out, 0);
        chk("rst_left", left_out, 0);
        chk("rst_right", right_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overrun", overrun, 0);
        start  = 1'b0;
        resetn = 1'b1;
        step(1);
        chk("idle_busy", busy, 0);

        // One-shot, three samples
        done_cnt = 0;
        launch(14'd100, 14'd3, 1'b0, 3'd0, n);
        push(32'h1400_0000, n + 2);
        push(32'hF400_0000, n + 2 + DIV);
        push(32'h7C00_0000, n + 2 + 2 * DIV);
        chk("os_busy", busy, 1);
        chk("os_rom_addr", rom_addr, 100);
        goto_cyc(n + 3 * DIV - 1);
        chk("os_done_early", done, 0);
        goto_cyc(n + 3 * DIV);
        chk("os_done", done, 1);
        chk("os_busy_end", busy, 0);
        chk("os_left_end", left_out, 0);
        step(1);
        chk("os_done_pulse", done, 0);
        chk("os_done_cnt", done_cnt, 1);
        chk("os_sb_empty", sb_q.size(), 0);

        // Loop across the address wrap
        done_cnt = 0;
        launch(14'd16383, 14'd2, 1'b1, 3'd0, n);
        for (int k = 0; k < 4; k++) push((k % 2 == 0) ? 32'h1C00_0000 : 32'hFC00_0000,
                                         n + 2 + k * DIV);
        for (int k = 0; k < 4; k++) begin
            goto_cyc(n + k * DIV + 1);
            chk("loop_rom_addr", rom_addr, (k % 2 == 0) ? 16383 : 0);
        end
        goto_cyc(n + 3 * DIV + 4);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("loop_stop_busy", busy, 0);
        chk("loop_stop_write", write_out, 0);
        chk("loop_stop_left", left_out, 0);
        chk("loop_done_cnt", done_cnt, 0);
        chk("loop_sb_empty", sb_q.size(), 0);

        // Backpressure for 1.5 periods: one pending tick, no overrun
        allowed = 1'b0;
        launch(14'd300, 14'd2, 1'b0, 3'd0, n);
        push(32'h2800_0000, n + DIV + DIV / 2);
        push(32'hD800_0000, n + DIV + DIV / 2 + 4);
        goto_cyc(n + DIV + DIV / 2);
        allowed = 1'b1;
        goto_cyc(n + 2 * DIV);
        chk("bp1_done", done, 1);
        chk("bp1_overrun", overrun, 0);

        // Backpressure for 2.5 periods: second tick overruns
        allowed = 1'b0;
        launch(14'd300, 14'd2, 1'b0, 3'd0, n);
        push(32'h2800_0000, n + 2 * DIV + DIV / 2);
        push(32'hD800_0000, n + 2 * DIV + DIV / 2 + 4);
        goto_cyc(n + DIV + 1);
        chk("bp2_no_overrun_yet", overrun, 0);
        goto_cyc(n + 2 * DIV + 1);
        chk("bp2_overrun", overrun, 1);
        goto_cyc(n + 2 * DIV + DIV / 2);
        allowed = 1'b1;
        goto_cyc(n + 3 * DIV);
        chk("bp2_done", done, 1);
        step(2);
        chk("bp2_overrun_sticky", overrun, 1);

        // Volume attenuation; the start also clears overrun
        launch(14'd200, 14'd1, 1'b0, 3'd2, n);
        chk("vol_overrun_clr", overrun, 0);
        push(32'hE000_0000, n + 2);
        goto_cyc(n + DIV + 1);
        chk("vol2_idle", busy, 0);
        launch(14'd201, 14'd1, 1'b0, 3'd7, n);
        push(32'h0008_0000, n + 2);
        goto_cyc(n + DIV + 1);
        chk("vol7_idle", busy, 0);

        // Stop and start together mid-clip: stop wins, no done
        done_cnt = 0;
        launch(14'd100, 14'd3, 1'b0, 3'd0, n);
        push(32'h1400_0000, n + 2);
        goto_cyc(n + 5);
        stop      = 1'b1;
        start     = 1'b1;
        clip_base = 14'd200;
        clip_len  = 14'd1;
        step(1);
        stop  = 1'b0;
        start = 1'b0;
        chk("ss_busy", busy, 0);
        chk("ss_write", write_out, 0);
        chk("ss_left", left_out, 0);
        step(3 * DIV);
        chk("ss_done_cnt", done_cnt, 0);
        chk("ss_still_idle", busy, 0);

        // Zero-length start is ignored
        clip_len  = 14'd0;
        clip_base = 14'd5;
        start     = 1'b1;
        step(1);
        start = 1'b0;
        chk("len0_busy", busy, 0);
        step(3);
        chk("len0_write", write_out, 0);
        chk("len0_busy_later", busy, 0);

        // Retrigger while a sample is stuck in PUSH
        allowed = 1'b0;
        launch(14'd100, 14'd3, 1'b0, 3'd0, n);
        goto_cyc(n + 4);
        chk("rt_push_write", write_out, 1);
        clip_base = 14'd200;
        clip_len  = 14'd1;
        loop_en   = 1'b0;
        start     = 1'b1;
        n2        = cyc + 1;
        step(1);
        start = 1'b0;
        push(32'h8000_0000, n2 + 2);
        chk("rt_rom_addr", rom_addr, 200);
        chk("rt_write0", write_out, 0);
        step(1);
        chk("rt_write1", write_out, 0);
        step(1);
        chk("rt_write2", write_out, 1);
        allowed = 1'b1;
        goto_cyc(n2 + DIV + 1);
        chk("rt_idle", busy, 0);

        step(2);
        chk("final_sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
